// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA frame-timing controller.
// Owns the horizontal/vertical scan counters, decodes sync/blank/visible
// signals, runs the IDLE/RUN/DRAIN start-stop FSM and (optionally) the
// per-line fetch handshake towards the pixel line buffer.
// Optional feature macro: VGA_LINE_FETCH_EN (line_req/line_ack/underrun).
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        enable_V_counter,
  output logic        frame_start,
  output logic        line_req,
  input  logic        line_ack,
  output logic        underrun
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_busy;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_ev;
  logic             r_frame_start;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_adv;
  logic             w_wrap;
  logic             w_frame_start_nxt;
  logic             w_clr_underrun;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_run_nxt;
  logic             w_video_nxt;
  logic             w_hs_act;
  logic             w_vs_act;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  // Next-state and counter advance; the counters move only on en while scanning.
  always_comb begin
    w_state_nxt       = r_state;
    w_h_nxt           = r_h;
    w_v_nxt           = r_v;
    w_adv             = 1'b0;
    w_wrap            = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_clr_underrun    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt       = ST_RUN;
          w_h_nxt           = '0;
          w_v_nxt           = '0;
          w_frame_start_nxt = 1'b1;
          w_clr_underrun    = 1'b1;
        end
      end
      ST_RUN: begin
        w_adv = en;
        if (stop) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_adv = en;
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
        end else if (en && w_h_last && w_v_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_adv) begin
      if (w_h_last) begin
        w_h_nxt = '0;
        w_wrap  = 1'b1;
        w_v_nxt = w_v_last ? '0 : r_v + CNT_W'(1);
      end else begin
        w_h_nxt = r_h + CNT_W'(1);
      end
      // A wrap to (0,0) that ends a drain is silent; only scanning frames announce.
      if (w_h_last && w_v_last && (w_state_nxt == ST_RUN)) w_frame_start_nxt = 1'b1;
    end
  end

  // Decode from the next counter values so outputs line up with pixel_x/pixel_y.
  always_comb begin
    w_run_nxt   = (w_state_nxt != ST_IDLE);
    w_video_nxt = w_run_nxt && (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
    w_hs_act    = w_run_nxt && (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
    w_vs_act    = w_run_nxt && (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
  end

  // State, counter and decoded-output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_h           <= '0;
      r_v           <= '0;
      r_busy        <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_ev          <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_busy        <= w_run_nxt;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_video_nxt;
      r_ev          <= w_wrap;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign busy             = r_busy;
  assign hsync            = r_hsync;
  assign vsync            = r_vsync;
  assign video_on         = r_video_on;
  assign pixel_x          = r_h;
  assign pixel_y          = r_v;
  assign enable_V_counter = r_ev;
  assign frame_start      = r_frame_start;

`ifdef VGA_LINE_FETCH_EN
  logic             r_line_req;
  logic             r_underrun;
  logic             w_line_req_nxt;
  logic             w_underrun_nxt;
  logic [CNT_W-1:0] w_v_next_line;

  assign w_v_next_line = (w_v_nxt == V_LAST) ? '0 : w_v_nxt + CNT_W'(1);

  // Fetch handshake: request the following line once the visible part of this one ends.
  always_comb begin
    w_line_req_nxt = r_line_req;
    w_underrun_nxt = r_underrun;
    if (r_line_req && line_ack) w_line_req_nxt = 1'b0;
    if (w_adv && (w_h_nxt == H_ACT) && (w_v_next_line < V_ACT)) w_line_req_nxt = 1'b1;
    // Request still pending as a visible line begins: the fetch was late.
    if (w_wrap && w_run_nxt && r_line_req && !line_ack && (w_v_nxt < V_ACT)) w_underrun_nxt = 1'b1;
    if (w_clr_underrun) w_underrun_nxt = 1'b0;
    if (!w_run_nxt) w_line_req_nxt = 1'b0;
  end

  // Fetch handshake registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_line_req <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_line_req <= w_line_req_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign line_req = r_line_req;
  assign underrun = r_underrun;
`else
  logic w_unused;

  assign w_unused = line_ack ^ w_clr_underrun;
  assign line_req = 1'b0;
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl with a small 8x6 frame.
// The reference model tracks the scan as a linear pixel index within the frame.
module tb_vga_timing_ctrl;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int HA = 4;
  localparam int VA = 3;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        line_ack = 1'b0;
  logic        busy, hsync, vsync, video_on, enable_V_counter, frame_start, line_req, underrun;
  logic [15:0] pixel_x, pixel_y;

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .busy(busy), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .enable_V_counter(enable_V_counter), .frame_start(frame_start),
    .line_req(line_req), .line_ack(line_ack), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_busy, m_drain, m_req, m_und, m_ev, m_fs;
  int m_pos;
  int req_age;
  int ack_mode;  // 0: ack 2 cycles after request, 1: withhold, 2: always high, 3: random

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int h, v;
    h = m_pos % HT;
    v = m_pos / HT;
    chk("busy", 16'(busy), 16'(m_busy));
    chk("pixel_x", pixel_x, 16'(m_busy ? h : 0));
    chk("pixel_y", pixel_y, 16'(m_busy ? v : 0));
    chk("video_on", 16'(video_on), 16'(m_busy && h < HA && v < VA));
    chk("hsync", 16'(hsync), 16'(!(m_busy && h >= 5 && h < 7)));
    chk("vsync", 16'(vsync), 16'(!(m_busy && v == 4)));
    chk("enable_V_counter", 16'(enable_V_counter), 16'(m_ev));
    chk("frame_start", 16'(frame_start), 16'(m_fs));
    chk("line_req", 16'(line_req), 16'(m_req));
    chk("underrun", 16'(underrun), 16'(m_und));
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_req = 0; m_und = 0; m_ev = 0; m_fs = 0;
    m_pos = 0; req_age = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit p, input bit a);
    bit adv, last, old_req;
    int h, v;
    adv = 0;
    old_req = m_req;
    m_ev = 0;
    m_fs = 0;
    if (!m_busy) begin
      if (s && !p) begin
        m_busy = 1; m_drain = 0; m_pos = 0; m_fs = 1; m_und = 0;
      end
    end else begin
      last = (m_pos == FRAME - 1);
      adv = e;
      if (adv) m_pos = (m_pos + 1) % FRAME;
      if (m_drain) begin
        if (s && !p) m_drain = 0;
        else if (adv && last) begin m_busy = 0; m_drain = 0; end
      end else if (p) begin
        m_drain = 1;
      end
      m_ev = adv && (m_pos % HT == 0);
      m_fs = adv && (m_pos == 0) && m_busy && !m_drain;
    end
    h = m_pos % HT;
    v = m_pos / HT;
`ifdef VGA_LINE_FETCH_EN
    if (old_req && a) m_req = 0;
    if (adv && h == HA && ((v + 1) % VT) < VA) m_req = 1;
    if (adv && h == 0 && old_req && !a && v < VA && m_busy) m_und = 1;
    if (!m_busy) m_req = 0;
`else
    m_req = 0;
    m_und = 0;
    if (old_req || a || h < 0) m_req = 0;
`endif
    if (m_req) req_age = req_age + 1;
    else req_age = 0;
  endtask

  task automatic tick(input bit t_en, input bit t_start, input bit t_stop);
    bit a;
    case (ack_mode)
      0: a = m_req && (req_age >= 2);
      1: a = 0;
      2: a = 1;
      default: a = 1'($urandom_range(0, 1));
    endcase
    en = t_en; start = t_start; stop = t_stop; line_ack = a;
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(t_en, t_start, t_stop, a);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int ev_cnt, ev_last, hs_low, vs_low, vid_cnt, req_rise, prev_req, ev_run, ev_max;
    model_reset();
    ack_mode = 2;
    @(negedge clk);

    // Reset for two cycles, then start
    rst = 0;
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("rst_hsync", 16'(hsync), 16'd1);
    chk("rst_vsync", 16'(vsync), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1;
    tick(1, 0, 0);
    tick(0, 1, 0);
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_frame_start", 16'(frame_start), 16'd1);
    chk("start_xy", {pixel_x[7:0], pixel_y[7:0]}, 16'd0);
    chk("start_video_on", 16'(video_on), 16'd1);

    // Full-frame sweep with line_ack held high
    ev_cnt = 0; ev_last = -1; hs_low = 0; vs_low = 0; vid_cnt = 0;
    for (int i = 1; i <= FRAME; i++) begin
      tick(1, 0, 0);
      if (enable_V_counter) begin
        if (ev_last >= 0) chk("ev_gap", 16'(i - ev_last), 16'd8);
        ev_last = i;
        ev_cnt++;
      end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video_on) vid_cnt++;
      if (i < FRAME) chk("no_early_frame_start", 16'(frame_start), 16'd0);
    end
    chk("ev_count", 16'(ev_cnt), 16'd6);
    chk("hsync_low_count", 16'(hs_low), 16'd12);
    chk("vsync_low_count", 16'(vs_low), 16'd8);
    chk("video_on_count", 16'(vid_cnt), 16'd12);
    chk("frame_recur", 16'(frame_start), 16'd1);
    chk("frame_recur_xy", {pixel_x[7:0], pixel_y[7:0]}, 16'd0);
    chk("no_fetch_with_ack_high", 16'(line_req), 16'(m_req));

    // en toggling: one advance per two clocks, one-clock wrap pulses
    ev_run = 0; ev_max = 0;
    for (int i = 0; i < 40; i++) begin
      tick(i % 2 == 0, 0, 0);
      ev_run = enable_V_counter ? ev_run + 1 : 0;
      if (ev_run > ev_max) ev_max = ev_run;
    end
    chk("ev_width", 16'(ev_max), 16'd1);
    for (int i = 0; i < 40; i++) tick(($urandom % 3) != 0, 0, 0);

    // Stop at (2,1), drain the frame, land in IDLE at (0,0)
    for (int i = 0; i < 2 * FRAME && m_pos != HT + 2; i++) tick(1, 0, 0);
    chk("at_2_1", {pixel_x[7:0], pixel_y[7:0]}, 16'h0201);
    tick(1, 0, 1);
    for (int i = 0; i < 2 * FRAME && m_busy; i++) tick(1, 0, 0);
    chk("drain_idle_busy", 16'(busy), 16'd0);
    chk("drain_idle_xy", {pixel_x[7:0], pixel_y[7:0]}, 16'd0);
    chk("drain_no_frame_start", 16'(frame_start), 16'd0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0);

    // Start during DRAIN resumes without disturbing counters
    tick(1, 1, 0);
    for (int i = 0; i < 13; i++) tick(1, 0, 0);
    tick(1, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("resume_busy", 16'(busy), 16'd1);
    chk("resume_x", pixel_x, 16'd3);
    // start and stop together: stop wins
    tick(1, 1, 1);
    for (int i = 0; i < 2 * FRAME && m_busy; i++) tick(1, 0, 0);
    tick(1, 1, 1);
    chk("idle_start_stop", 16'(busy), 16'd0);

    // Line fetch: timely acks, then a withheld ack
    tick(1, 1, 0);
    ack_mode = 0;
    req_rise = 0; prev_req = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1, 0, 0);
      if (line_req && !prev_req) begin
        req_rise++;
        chk("req_rise_h", pixel_x, 16'd4);
      end
      prev_req = line_req;
    end
`ifdef VGA_LINE_FETCH_EN
    chk("req_rise_count", 16'(req_rise), 16'd3);
`else
    chk("req_rise_count", 16'(req_rise), 16'd0);
`endif
    chk("no_underrun", 16'(underrun), 16'd0);
    ack_mode = 1;
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
`ifdef VGA_LINE_FETCH_EN
    chk("underrun_set", 16'(underrun), 16'd1);
`else
    chk("underrun_set", 16'(underrun), 16'd0);
`endif
    ack_mode = 0;
    tick(1, 0, 1);
    for (int i = 0; i < 2 * FRAME && m_busy; i++) tick(1, 0, 0);
    tick(1, 0, 0);
    chk("underrun_sticky_idle", 16'(underrun), 16'(m_und));
    tick(1, 1, 0);
    chk("underrun_clear_on_start", 16'(underrun), 16'd0);

    // Reset mid-frame
    for (int i = 0; i < 12; i++) tick(1, 0, 0);
    rst = 0;
    tick(1, 0, 0);
    rst = 1;
    chk("midreset_busy", 16'(busy), 16'd0);
    chk("midreset_hsync", 16'(hsync), 16'd1);

    // Randomized control, pixel tick and ack
    ack_mode = 3;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 200) != 0;
      tick(($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 24) == 0);
    end
    rst = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Frame-timing controller for the VGA output path. Owns the horizontal pixel counter and sequences the vertical line count. Decodes sync, blanking and visible-area signals, and runs a start/stop control FSM plus a per-line fetch handshake towards the pixel line buffer. Sits between the register interface (start/stop) and the VGA pads/line buffer; its `enable_V_counter` output drives the vertical line-advance input of the vertical counting logic.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: asserted level of hsync/vsync (0 = active-low)

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset. Synchronous, active-low: sampled on `clk` rising edge while 0.
- `en` in 1: pixel tick; counters advance only on cycles with `en`=1.
- `start` in 1: one-cycle pulse; begin or resume scan.
- `stop` in 1: one-cycle pulse; finish the current frame, then idle.
- `busy` out 1: state ≠ IDLE.
- `hsync`, `vsync` out 1: sync outputs, polarity per `SYNC_POL`.
- `video_on` out 1: current pixel is in the visible area.
- `pixel_x`, `pixel_y` out 16: horizontal/vertical counter values.
- `enable_V_counter` out 1: one-cycle line-wrap pulse.
- `frame_start` out 1: one-cycle pulse when the counters enter (0,0).
- `line_req` out 1: request to the line buffer to fetch the next visible line.
- `line_ack` in 1: line buffer accepted the request.
- `underrun` out 1: sticky flag; a line fetch was late.

## Operation
- H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters. Both totals must be ≤ 65535.
- FSM states:
  - IDLE: reset state.
  - IDLE -> RUN on `start`: `pixel_x`/`pixel_y` load 0, `frame_start` pulses, `underrun` clears.
  - RUN -> DRAIN on `stop`.
  - DRAIN -> RUN on `start`; counters are not disturbed.
  - DRAIN -> IDLE on the `en` cycle where (h,v) = (H_TOTAL-1, V_TOTAL-1). The counters return to 0 and no `frame_start` pulse is issued.
  - `start` and `stop` in the same cycle: `stop` wins.
- Counters hold in IDLE.
- In RUN/DRAIN with `en`=1:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0.
- Decode, all from the new counter values:
  - `video_on` = h<H_ACTIVE && v<V_ACTIVE.
  - `hsync` is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - `vsync` is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
- In IDLE: `video_on`=0, syncs at the deasserted level.
- `enable_V_counter` is high for exactly one clk cycle each time h wraps to 0.
- `frame_start` is high for one cycle each time (h,v) becomes (0,0) in RUN, including entry from IDLE.
- Line fetch:
  - `line_req` rises when h becomes H_ACTIVE and line (v+1) mod V_TOTAL < V_ACTIVE.
  - `line_req` holds until `line_ack`=1 is sampled, then falls on the next edge.
  - `line_ack` is ignored while `line_req`=0.
  - If `line_req` is still high when h wraps to 0 into a visible line, `underrun` sets. `line_req` stays high until acked.
  - Entering IDLE drops `line_req`.

## Timing
- Reset values: `busy`=0, `video_on`=0, `pixel_x`=`pixel_y`=0, `enable_V_counter`=0, `frame_start`=0, `line_req`=0, `underrun`=0, `hsync`=`vsync`=!SYNC_POL.
- Reset mid-frame returns every output to its reset value on that edge.
- All outputs are registered and updated on the same edge as the counters. There is zero latency between `pixel_x`/`pixel_y` and their decodes.
- `start` to RUN is 1 clk, independent of `en`.
- Counter progression always requires `en`.
- `line_ack` to `line_req` deassertion is 1 clk.

## Configuration
- `VGA_LINE_FETCH_EN` defined: the line-fetch handshake and `underrun` are implemented as above.
- Undefined: `line_req` and `underrun` are tied 0, `line_ack` is ignored, and no fetch logic is synthesized.

## Test plan
Bench parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), SYNC_POL 0, `en`=1 unless noted.
- Reset check: reset low 2 cycles, then `start`.
  - After reset, all outputs are at reset values and `hsync`=`vsync`=1.
  - After `start`: `busy`=1, `frame_start` pulses once, (0,0), `video_on`=1.
- Full-frame sweep, one frame:
  - `hsync`=0 exactly at h=5,6.
  - `vsync`=0 exactly at v=4.
  - `video_on` only for h<4, v<3.
  - `enable_V_counter` pulses 6 times, 8 cycles apart.
  - (0,0) recurs after 48 cycles.
- `en` toggling every other cycle: counters advance once per two clocks and every wrap pulse still lasts one clk.
- `stop` at (2,1):
  - Frame completes through (7,5), then `busy`=0 with counters at 0 and no `frame_start`.
  - `start` issued during DRAIN keeps `busy`=1 without a counter glitch.
- Line fetch (macro defined):
  - `line_req` rises at h=4 of lines 0, 1 and 5; `line_ack` after 2 cycles drops it next edge; `underrun`=0.
  - Withholding `line_ack` past the wrap sets `underrun`, which stays 1 until the next `start` from IDLE.
- Macro undefined: `line_ack` driven high continuously leaves `line_req`=`underrun`=0 for a full frame.
